// File: rtl/x74595.sv
// x74595 - serial-in / parallel-out shift register with output storage
// register, in the style of a 74x595. The pin strobes are synchronised into
// clk_sys-style single clock domain `clk` and edge-detected.
//
// Parameters:
//   WIDTH        number of shift/storage stages (2..32)
//   SYNC_STAGES  depth of each pin synchroniser chain (2..4)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   SER       serial data pin
//   SRCLK     shift-clock pin (sampled as data, rising edge shifts)
//   RCLK      storage-clock pin (sampled as data, rising edge latches)
//   SRCLR_N   active-low shift-register clear (level, synchronised)
//   OE_N      active-low output enable for Q (not synchronised)
//   Q         parallel outputs, Q[0]=QA .. Q[WIDTH-1]=QH, 'z when disabled
//   QH_S      serial cascade output, last shift stage
//   FRAME_RDY only with X74595_FRAME_CNT_EN: a full WIDTH bits have been
//             shifted since the last storage strobe / clear
//   _vss0/_vdd0  power pads, no logic function
//
// Build option: define X74595_FRAME_CNT_EN to add the frame counter and the
// FRAME_RDY output.

module x74595 #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SER,
  input  logic             SRCLK,
  input  logic             RCLK,
  input  logic             SRCLR_N,
  input  logic             OE_N,
  output logic [WIDTH-1:0] Q,
  output logic             QH_S,
`ifdef X74595_FRAME_CNT_EN
  output logic             FRAME_RDY,
`endif
  inout  wire              _vss0,
  inout  wire              _vdd0
);

  // Power pads only join the internal supply nets.
  wire _vss;
  wire _vdd;
  assign _vss = _vss0;
  assign _vdd = _vdd0;
  wire pwr_unused = _vss ^ _vdd;

  logic [SYNC_STAGES-1:0] ser_sync_q,   ser_sync_d;
  logic [SYNC_STAGES-1:0] srclk_sync_q, srclk_sync_d;
  logic [SYNC_STAGES-1:0] rclk_sync_q,  rclk_sync_d;
  logic [SYNC_STAGES-1:0] clr_sync_q,   clr_sync_d;
  logic                   srclk_prev_q, srclk_prev_d;
  logic                   rclk_prev_q,  rclk_prev_d;
  logic [WIDTH-1:0]       sr_q, sr_d;
  logic [WIDTH-1:0]       st_q, st_d;

  logic ser_s;
  logic srclk_rise;
  logic rclk_rise;
  logic clr_active;

  // SER and SRCLK chains share the same depth so data stays aligned to the
  // shift strobe.
  assign ser_s      = ser_sync_q[SYNC_STAGES-1];
  assign srclk_rise = srclk_sync_q[SYNC_STAGES-1] & ~srclk_prev_q;
  assign rclk_rise  = rclk_sync_q[SYNC_STAGES-1] & ~rclk_prev_q;
  assign clr_active = ~clr_sync_q[SYNC_STAGES-1];

  always_comb begin
    ser_sync_d   = {ser_sync_q[SYNC_STAGES-2:0], SER};
    srclk_sync_d = {srclk_sync_q[SYNC_STAGES-2:0], SRCLK};
    rclk_sync_d  = {rclk_sync_q[SYNC_STAGES-2:0], RCLK};
    clr_sync_d   = {clr_sync_q[SYNC_STAGES-2:0], SRCLR_N};
    srclk_prev_d = srclk_sync_q[SYNC_STAGES-1];
    rclk_prev_d  = rclk_sync_q[SYNC_STAGES-1];

    // Storage always takes the pre-update shift value, even when a shift or
    // a clear lands in the same cycle.
    st_d = st_q;
    if (rclk_rise) st_d = sr_q;

    sr_d = sr_q;
    if (clr_active)      sr_d = '0;
    else if (srclk_rise) sr_d = {sr_q[WIDTH-2:0], ser_s};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ser_sync_q   <= '0;
      srclk_sync_q <= '0;
      rclk_sync_q  <= '0;
      clr_sync_q   <= '0;
      srclk_prev_q <= 1'b0;
      rclk_prev_q  <= 1'b0;
      sr_q         <= '0;
      st_q         <= '0;
    end else begin
      ser_sync_q   <= ser_sync_d;
      srclk_sync_q <= srclk_sync_d;
      rclk_sync_q  <= rclk_sync_d;
      clr_sync_q   <= clr_sync_d;
      srclk_prev_q <= srclk_prev_d;
      rclk_prev_q  <= rclk_prev_d;
      sr_q         <= sr_d;
      st_q         <= st_d;
    end
  end

  assign Q    = OE_N ? {WIDTH{1'bz}} : st_q;
  assign QH_S = sr_q[WIDTH-1];

`ifdef X74595_FRAME_CNT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_rdy_q, frame_rdy_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_active)
      cnt_d = '0;
    else if (rclk_rise)
      // a shift in the storage cycle is the first bit of the next frame
      cnt_d = srclk_rise ? CNT_W'(1) : '0;
    else if (srclk_rise && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
    frame_rdy_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      frame_rdy_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_rdy_q <= frame_rdy_d;
    end
  end

  assign FRAME_RDY = frame_rdy_q;
`endif

endmodule

// File: tb/tb_x74595.sv
module tb_x74595;
  localparam int W = 8;
  localparam int S = 2;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n, ser, srclk, rclk, srclr_n, oe_n;
  wire [W-1:0] q;
  wire qh_s;
  wire vss, vdd;
  assign vss = 1'b0;
  assign vdd = 1'b1;
`ifdef X74595_FRAME_CNT_EN
  wire frame_rdy;
`endif

  int checks = 0;
  int errors = 0;

  x74595 #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .SER(ser), .SRCLK(srclk), .RCLK(rclk),
    .SRCLR_N(srclr_n), .OE_N(oe_n), .Q(q), .QH_S(qh_s),
`ifdef X74595_FRAME_CNT_EN
    .FRAME_RDY(frame_rdy),
`endif
    ._vss0(vss), ._vdd0(vdd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Disabled outputs must not drive the stored value; a 2-state simulator may
  // resolve the undriven bus to 0, so that is accepted too.
  task automatic chk_hiz(input string name);
    checks++;
    if (!(q === {W{1'bz}} || q === {W{1'b0}})) begin
      errors++;
      $display("FAIL %s actual=%b required=high-z", name, q);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin history: bit 0 is the value seen at the most recent clk edge. A pin
  // value takes effect S edges after it was first seen, and an edge is that
  // value being 1 while the one before it was 0.
  logic [7:0] h_ser, h_srclk, h_rclk, h_clr;
  int m_sr, m_st, m_cnt;
  bit m_valid = 0;
  int n_sr, n_st, n_cnt;
  bit srise, rrise, mclr;

  always_comb begin
    srise = h_srclk[S-1] && !h_srclk[S];
    rrise = h_rclk[S-1] && !h_rclk[S];
    mclr  = !h_clr[S-1];
    n_st  = rrise ? m_sr : m_st;
    if (mclr)       n_sr = 0;
    else if (srise) n_sr = ((m_sr * 2) + int'(h_ser[S-1])) & MASK;
    else            n_sr = m_sr;
    if (mclr)       n_cnt = 0;
    else if (rrise) n_cnt = srise ? 1 : 0;
    else if (srise) n_cnt = (m_cnt < W) ? m_cnt + 1 : W;
    else            n_cnt = m_cnt;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      h_ser <= '0; h_srclk <= '0; h_rclk <= '0; h_clr <= '0;
      m_sr <= 0; m_st <= 0; m_cnt <= 0; m_valid <= 1;
    end else begin
      h_ser   <= {h_ser[6:0], ser};
      h_srclk <= {h_srclk[6:0], srclk};
      h_rclk  <= {h_rclk[6:0], rclk};
      h_clr   <= {h_clr[6:0], srclr_n};
      m_sr <= n_sr; m_st <= n_st; m_cnt <= n_cnt;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      if (!oe_n) chk("q_vs_model", 32'(q), 32'(m_st));
      chk("qhs_vs_model", 32'(qh_s), 32'((m_sr >> (W - 1)) & 1));
`ifdef X74595_FRAME_CNT_EN
      chk("frame_rdy_vs_model", 32'(frame_rdy), 32'(m_cnt == W));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic shift_bit(input logic b);
    ser = b; srclk = 1'b1; tick(4);
    srclk = 1'b0; tick(4);
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic pulse_rclk();
    rclk = 1'b1; tick(4);
    rclk = 1'b0; tick(4);
  endtask

  task automatic pulse_tied(input logic b);
    ser = b; srclk = 1'b1; rclk = 1'b1; tick(4);
    srclk = 1'b0; rclk = 1'b0; tick(4);
  endtask

  initial begin
    rst_n = 1'b0; ser = 1'b0; srclk = 1'b0; rclk = 1'b0;
    srclr_n = 1'b1; oe_n = 1'b0;
    tick(3);
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_qhs", 32'(qh_s), 32'h0);
    oe_n = 1'b1; #1;
    chk_hiz("reset_q_disabled");
    oe_n = 1'b0;
    rst_n = 1'b1;
    tick(S + 2);

    // basic load: first bit ends in QH
    shift_byte(8'hB2);
    chk("basic_qhs_after_8", 32'(qh_s), 32'h1);
    rclk = 1'b1;
    for (int i = 1; i <= S; i++) begin
      tick(1);
      chk("rclk_latency_hold", 32'(q), 32'h00);
    end
    tick(1);
    chk("basic_q_b2", 32'(q), 32'hB2);
    tick(4 - (S + 1));
    rclk = 1'b0; tick(4);
    oe_n = 1'b1; #1;
    chk_hiz("b2_q_disabled");
    oe_n = 1'b0;

    // clear beats a same-cycle shift; storage untouched until next RCLK
    shift_byte(8'hA5);
    chk("a5_qhs", 32'(qh_s), 32'h1);
    srclr_n = 1'b0;
    shift_bit(1'b1);
    srclr_n = 1'b1;
    tick(S + 2);
    chk("clear_qhs", 32'(qh_s), 32'h0);
    chk("clear_q_kept", 32'(q), 32'hB2);
    pulse_rclk();
    chk("clear_q_after_rclk", 32'(q), 32'h00);

    // tied strobes: storage takes the value from before each shift
    for (int i = 0; i < 8; i++) pulse_tied(1'b1);
    chk("tied_q_8", 32'(q), 32'h7F);
    pulse_tied(1'b1);
    chk("tied_q_9", 32'(q), 32'hFF);

    // single-clk glitch (model tracks whether it is taken), then reset
    // in the middle of a byte
    ser = 1'b0; srclk = 1'b1; tick(1);
    srclk = 1'b0; tick(4);
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    rst_n = 1'b0; tick(2);
    chk("midreset_q", 32'(q), 32'h00);
    rst_n = 1'b1;
    tick(S + 2);
    shift_byte(8'h3C);
    pulse_rclk();
    chk("after_reset_q_3c", 32'(q), 32'h3C);

`ifdef X74595_FRAME_CNT_EN
    for (int i = 0; i < 7; i++) shift_bit(1'b0);
    chk("frame_rdy_7", 32'(frame_rdy), 32'h0);
    shift_bit(1'b1);
    chk("frame_rdy_8", 32'(frame_rdy), 32'h1);
    shift_bit(1'b1);
    chk("frame_rdy_9", 32'(frame_rdy), 32'h1);
    pulse_rclk();
    chk("frame_rdy_rclk", 32'(frame_rdy), 32'h0);
    pulse_tied(1'b1);
    for (int i = 0; i < 6; i++) shift_bit(1'b0);
    chk("frame_rdy_cnt1_plus6", 32'(frame_rdy), 32'h0);
    shift_bit(1'b0);
    chk("frame_rdy_cnt1_plus7", 32'(frame_rdy), 32'h1);
`endif

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
